// File: rtl/regfile_sb.sv
// rtl/regfile_sb.sv - register file with two read ports, one write port and a per-register busy scoreboard
//
// Purpose:
//   DEPTH x WIDTH register file for the multicycle datapath. Each register
//   carries a busy bit. Issue of a producer sets the bit through rsv_en and
//   rsv_addr. Writeback through we and wa clears it, so control can see
//   read-after-write hazards. Register 0 can be hardwired to zero. Same-cycle
//   write data can be forwarded to the read ports.
//
// Ports:
//   clk        rising-edge clock for all state
//   reset      asynchronous active-high clear of data, busy bits and count
//   ra1, ra2   read addresses
//   rd1, rd2   combinational read data
//   we, wa, wd synchronous write port; clears busy[wa]
//   rsv_en     reserve request; sets busy[rsv_addr]
//   rsv_addr   register to reserve
//   busy1/2    busy bit of ra1/ra2 (from state, never forwarded)
//   busy_count registered population count of the busy vector

module regfile_sb #(
    parameter int WIDTH    = 32,
    parameter int DEPTH    = 32,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1,
    localparam int AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [AW-1:0]    ra1,
    input  logic [AW-1:0]    ra2,
    output logic [WIDTH-1:0] rd1,
    output logic [WIDTH-1:0] rd2,
    input  logic             we,
    input  logic [AW-1:0]    wa,
    input  logic [WIDTH-1:0] wd,
    input  logic             rsv_en,
    input  logic [AW-1:0]    rsv_addr,
    output logic             busy1,
    output logic             busy2,
    output logic [AW:0]      busy_count
);

    localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [DEPTH-1:0] busy;
    logic [DEPTH-1:0] busy_nxt;
    logic [AW:0]      count_nxt;

    logic wr_ok;
    logic rsv_ok;
    logic ra1_ok;
    logic ra2_ok;

    // An address is usable when it names a real register. The hardwired zero
    // register is excluded too, because it neither stores data nor can be reserved.
    function automatic logic addr_ok(input logic [AW-1:0] a);
        logic in_range;
        in_range = ({1'b0, a} < DEPTH_W);
        return in_range && !((ZERO_REG != 0) && (a == '0));
    endfunction

    assign wr_ok  = we && addr_ok(wa);
    assign rsv_ok = rsv_en && addr_ok(rsv_addr);
    assign ra1_ok = addr_ok(ra1);
    assign ra2_ok = addr_ok(ra2);

    // The clear is applied first and the set second. A producer that issues
    // in the same cycle as writeback therefore keeps the register busy.
    always_comb begin
        busy_nxt = busy;
        if (wr_ok) begin
            busy_nxt[wa] = 1'b0;
        end
        if (rsv_ok) begin
            busy_nxt[rsv_addr] = 1'b1;
        end
    end

    // The count is recomputed from the next vector rather than tracked
    // incrementally. It cannot drift from the vector and cannot wrap.
    always_comb begin
        count_nxt = '0;
        for (int i = 0; i < DEPTH; i++) begin
            count_nxt = count_nxt + {{AW{1'b0}}, busy_nxt[i]};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            busy       <= '0;
            busy_count <= '0;
        end else begin
            if (wr_ok) begin
                mem[wa] <= wd;
            end
            busy       <= busy_nxt;
            busy_count <= count_nxt;
        end
    end

    // A matching valid read address implies a valid write address, so the
    // forward needs no separate write-validity check.
    always_comb begin
        rd1 = '0;
        if (ra1_ok) begin
            if ((BYPASS != 0) && we && (wa == ra1)) begin
                rd1 = wd;
            end else begin
                rd1 = mem[ra1];
            end
        end
    end

    always_comb begin
        rd2 = '0;
        if (ra2_ok) begin
            if ((BYPASS != 0) && we && (wa == ra2)) begin
                rd2 = wd;
            end else begin
                rd2 = mem[ra2];
            end
        end
    end

    assign busy1 = ra1_ok ? busy[ra1] : 1'b0;
    assign busy2 = ra2_ok ? busy[ra2] : 1'b0;

endmodule

// File: tb/tb_regfile_sb.sv
// tb/tb_regfile_sb.sv - self-checking bench for regfile_sb across four parameter sets
//
// Instances: 0 default, 1 BYPASS=0, 2 ZERO_REG=0, 3 DEPTH=24. All four share one stimulus.

module tb_regfile_sb;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [4:0]  ra1 = '0, ra2 = '0, wa = '0, rsv_addr = '0;
    logic        we = 1'b0, rsv_en = 1'b0;
    logic [31:0] wd = '0;

    logic [31:0] rd1_o [4];
    logic [31:0] rd2_o [4];
    logic        busy1_o [4];
    logic        busy2_o [4];
    logic [5:0]  cnt_o [4];

    int n_vec = 0;
    int n_err = 0;

    int cfg_dep  [4] = '{32, 32, 32, 24};
    bit cfg_zero [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
    bit cfg_byp  [4] = '{1'b1, 1'b0, 1'b1, 1'b1};

    logic [31:0] m_mem  [4][32];
    bit          m_busy [4][32];

    always #5 clk = ~clk;

    regfile_sb #(.WIDTH(32), .DEPTH(32), .ZERO_REG(1), .BYPASS(1)) dut0 (
        .clk(clk), .reset(reset), .ra1(ra1), .ra2(ra2), .rd1(rd1_o[0]), .rd2(rd2_o[0]),
        .we(we), .wa(wa), .wd(wd), .rsv_en(rsv_en), .rsv_addr(rsv_addr),
        .busy1(busy1_o[0]), .busy2(busy2_o[0]), .busy_count(cnt_o[0]));
    regfile_sb #(.WIDTH(32), .DEPTH(32), .ZERO_REG(1), .BYPASS(0)) dut1 (
        .clk(clk), .reset(reset), .ra1(ra1), .ra2(ra2), .rd1(rd1_o[1]), .rd2(rd2_o[1]),
        .we(we), .wa(wa), .wd(wd), .rsv_en(rsv_en), .rsv_addr(rsv_addr),
        .busy1(busy1_o[1]), .busy2(busy2_o[1]), .busy_count(cnt_o[1]));
    regfile_sb #(.WIDTH(32), .DEPTH(32), .ZERO_REG(0), .BYPASS(1)) dut2 (
        .clk(clk), .reset(reset), .ra1(ra1), .ra2(ra2), .rd1(rd1_o[2]), .rd2(rd2_o[2]),
        .we(we), .wa(wa), .wd(wd), .rsv_en(rsv_en), .rsv_addr(rsv_addr),
        .busy1(busy1_o[2]), .busy2(busy2_o[2]), .busy_count(cnt_o[2]));
    regfile_sb #(.WIDTH(32), .DEPTH(24), .ZERO_REG(1), .BYPASS(1)) dut3 (
        .clk(clk), .reset(reset), .ra1(ra1), .ra2(ra2), .rd1(rd1_o[3]), .rd2(rd2_o[3]),
        .we(we), .wa(wa), .wd(wd), .rsv_en(rsv_en), .rsv_addr(rsv_addr),
        .busy1(busy1_o[3]), .busy2(busy2_o[3]), .busy_count(cnt_o[3]));

    // ---------------- behavioural model ----------------
    function automatic bit m_valid(int k, logic [4:0] a);
        return (int'(a) < cfg_dep[k]) && !(cfg_zero[k] && a == 5'd0);
    endfunction

    function automatic logic [31:0] m_rd(int k, logic [4:0] a);
        if (!m_valid(k, a)) return 32'h0;
        if (cfg_byp[k] && we && wa == a) return wd;
        return m_mem[k][a];
    endfunction

    function automatic logic [31:0] m_busyq(int k, logic [4:0] a);
        return (m_valid(k, a) && m_busy[k][a]) ? 32'd1 : 32'd0;
    endfunction

    function automatic logic [31:0] m_count(int k);
        int s = 0;
        for (int i = 0; i < 32; i++) s += int'(m_busy[k][i]);
        return s;
    endfunction

    always @(posedge clk or posedge reset) begin
        for (int k = 0; k < 4; k++) begin
            if (reset) begin
                for (int i = 0; i < 32; i++) begin
                    m_mem[k][i]  = 32'h0;
                    m_busy[k][i] = 1'b0;
                end
            end else begin
                if (we && m_valid(k, wa)) begin
                    m_mem[k][wa]  = wd;
                    m_busy[k][wa] = 1'b0;
                end
                if (rsv_en && m_valid(k, rsv_addr)) m_busy[k][rsv_addr] = 1'b1;
            end
        end
    end

    task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s dut%0d at %0t: got %h, expected %h", nm, k, $time, act, exp);
        end
    endtask

    // Compare every instance against the model on each falling edge.
    always @(negedge clk) begin
        for (int k = 0; k < 4; k++) begin
            chk("rd1", k, rd1_o[k], m_rd(k, ra1));
            chk("rd2", k, rd2_o[k], m_rd(k, ra2));
            chk("busy1", k, 32'(busy1_o[k]), m_busyq(k, ra1));
            chk("busy2", k, 32'(busy2_o[k]), m_busyq(k, ra2));
            chk("busy_count", k, 32'(cnt_o[k]), m_count(k));
        end
    end

    task automatic idle();
        we = 1'b0; rsv_en = 1'b0;
    endtask

    task automatic next();
        @(posedge clk); #1;
    endtask

    // ---------------- directed stimulus with literal expectations ----------------
    initial begin
        #2 reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        // reset clears state asynchronously
        next(); we = 1'b1; wa = 5'd5; wd = 32'hDEADBEEF;
        next(); we = 1'b0; rsv_en = 1'b1; rsv_addr = 5'd7;
        next(); idle(); ra1 = 5'd5;
        #1 chk("pre_reset_rd1", 0, rd1_o[0], 32'hDEADBEEF);
        chk("pre_reset_cnt", 0, 32'(cnt_o[0]), 32'd1);
        reset = 1'b1;
        #1 chk("reset_rd1", 0, rd1_o[0], 32'h0);
        chk("reset_cnt", 0, 32'(cnt_o[0]), 32'd0);
        ra1 = 5'd7;
        #1 chk("reset_busy1", 0, 32'(busy1_o[0]), 32'd0);
        reset = 1'b0;

        // write, read and bypass
        next(); we = 1'b1; wa = 5'd3; wd = 32'h11110000;
        next(); wd = 32'h12345678; ra1 = 5'd3;
        #2 chk("bypass_rd1", 0, rd1_o[0], 32'h12345678);
        chk("nobypass_rd1", 1, rd1_o[1], 32'h11110000);
        next(); idle();
        #2 chk("write_rd1", 0, rd1_o[0], 32'h12345678);
        chk("write_rd1", 1, rd1_o[1], 32'h12345678);

        // zero register
        next(); we = 1'b1; wa = 5'd0; wd = 32'hFFFFFFFF; rsv_en = 1'b1; rsv_addr = 5'd0; ra1 = 5'd0;
        #2 chk("zero_rd1_same", 0, rd1_o[0], 32'h0);
        chk("nozero_rd1_same", 2, rd1_o[2], 32'hFFFFFFFF);
        next(); idle();
        #2 chk("zero_rd1", 0, rd1_o[0], 32'h0);
        chk("zero_busy1", 0, 32'(busy1_o[0]), 32'd0);
        chk("zero_cnt", 0, 32'(cnt_o[0]), 32'd0);
        chk("nozero_rd1", 2, rd1_o[2], 32'hFFFFFFFF);
        chk("nozero_busy1", 2, 32'(busy1_o[2]), 32'd1);

        // scoreboard fill and clear
        for (int i = 0; i < 4; i++) begin
            next();
            if (i < 3) begin
                rsv_en = 1'b1; rsv_addr = (i == 0) ? 5'd4 : (i == 1) ? 5'd9 : 5'd12;
            end else begin
                rsv_en = 1'b0;
            end
            #2 if (i > 0) chk("sb_fill_cnt", 0, 32'(cnt_o[0]), 32'(i));
        end
        next(); we = 1'b1; wa = 5'd9; wd = 32'h00000099; ra2 = 5'd9;
        #2 chk("busy_not_bypassed", 0, 32'(busy2_o[0]), 32'd1);
        next(); idle();
        #2 chk("sb_clear_busy2", 0, 32'(busy2_o[0]), 32'd0);
        chk("sb_clear_cnt", 0, 32'(cnt_o[0]), 32'd2);

        // simultaneous reserve and write
        next(); rsv_en = 1'b1; rsv_addr = 5'd6;
        next(); we = 1'b1; wa = 5'd6; wd = 32'hA5A5A5A5; ra1 = 5'd6;
        #2 chk("rw_cnt_before", 0, 32'(cnt_o[0]), 32'd3);
        next(); idle();
        #2 chk("rw_rd1", 0, rd1_o[0], 32'hA5A5A5A5);
        chk("rw_busy1", 0, 32'(busy1_o[0]), 32'd1);
        chk("rw_cnt", 0, 32'(cnt_o[0]), 32'd3);

        // non-power-of-two depth
        next(); we = 1'b1; wa = 5'd30; wd = 32'h30303030; ra1 = 5'd30;
        #2 chk("d24_rd1", 3, rd1_o[3], 32'h0);
        chk("d24_busy1", 3, 32'(busy1_o[3]), 32'd0);
        next(); we = 1'b0; rsv_en = 1'b1; rsv_addr = 5'd30;
        #2 chk("d32_rd30", 0, rd1_o[0], 32'h30303030);
        chk("d24_rd30", 3, rd1_o[3], 32'h0);
        next(); idle();
        #2 chk("d24_cnt", 3, 32'(cnt_o[3]), 32'd3);
        chk("d32_cnt", 0, 32'(cnt_o[0]), 32'd4);
        chk("d32_busy30", 0, 32'(busy1_o[0]), 32'd1);

        // mixed traffic, checked by the compare process against the model
        for (int i = 0; i < 300; i++) begin
            next();
            reset    = ($urandom_range(0, 59) == 0);
            we       = $urandom_range(0, 1) == 1;
            wa       = 5'($urandom_range(0, 31));
            wd       = $urandom;
            rsv_en   = $urandom_range(0, 2) == 0;
            rsv_addr = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31));
            ra1      = ($urandom_range(0, 2) == 0) ? wa : 5'($urandom_range(0, 31));
            ra2      = 5'($urandom_range(0, 31));
        end
        next(); idle(); reset = 1'b0;
        repeat (2) next();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/regfile_sb.md
# regfile_sb

Parameterised register file with a per-register busy scoreboard for the multicycle CPU datapath. It generalises the single-word enabled register to DEPTH words of WIDTH bits, with two combinational read ports and one synchronous write port. It optionally hardwires register 0 to zero and optionally forwards same-cycle write data to the read ports. Each register carries a busy bit: the control FSM sets it when an instruction that will write that register issues, and the writeback clears it, so the control FSM can detect read-after-write hazards.

## Interface
- WIDTH, 32, data width in bits.
- DEPTH, 32, number of registers; need not be a power of two.
- ZERO_REG, 1, when 1, register 0 always reads 0, ignores writes and cannot be reserved.
- BYPASS, 1, when 1, same-cycle write data is forwarded to matching read ports.
- AW (derived, not overridable), $clog2(DEPTH), address width.

- clk  in  1  single clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- ra1  in  AW  read address, port 1.
- ra2  in  AW  read address, port 2.
- rd1  out  WIDTH  read data, port 1 (combinational).
- rd2  out  WIDTH  read data, port 2 (combinational).
- we  in  1  write enable.
- wa  in  AW  write address.
- wd  in  WIDTH  write data.
- rsv_en  in  1  reserve request: marks register rsv_addr busy.
- rsv_addr  in  AW  register to reserve.
- busy1  out  1  busy bit of register ra1 (combinational from state).
- busy2  out  1  busy bit of register ra2.
- busy_count  out  AW+1  number of registers currently busy.

## Operation
- Storage: DEPTH x WIDTH data array plus a DEPTH-bit busy vector.
- Write: at the clock edge, when we=1 and wa is valid, mem[wa] <= wd.
- Valid write address: wa < DEPTH, and wa != 0 when ZERO_REG=1. Invalid write addresses are dropped silently.
- Read, rdN:
  - 0 if raN >= DEPTH, or if raN == 0 with ZERO_REG=1.
  - Otherwise wd if BYPASS=1, we=1 and wa == raN.
  - Otherwise mem[raN].
- Bypass applies only to data; busyN is not bypassed.
- Scoreboard update at each edge, per register i:
  - Set when rsv_en=1 and rsv_addr == i.
  - Else cleared when we=1 and wa == i.
  - Else held.
- Reserve and write to the same register in the same cycle: the reservation wins and the busy bit stays 1, because a new producer has issued. The data is still written.
- Reservations of an invalid address (out of range, or 0 with ZERO_REG=1) are ignored.
- Writes clear busy whether or not the register was reserved. Clearing a non-busy register is legal and has no effect.
- busyN: 0 for invalid addresses; otherwise busy[raN].
- busy_count: population count of the busy vector, registered alongside it and consistent with the vector every cycle. Maximum value DEPTH (or DEPTH-1 with ZERO_REG=1); it cannot wrap.

## Timing
- Reset asserted, asynchronously with no clock needed:
  - All data words and busy bits go to 0.
  - rd1/rd2 read 0, busy1/busy2 = 0, busy_count = 0.
- Reset deasserted: the first state update occurs at the next rising edge.
- Reset wins over any same-edge we or rsv_en; pending writes and reservations are discarded.
- Write latency:
  - Data visible on rdN from the cycle after the edge.
  - With BYPASS=1, also visible in the same cycle as we.
- Busy latency: busyN and busy_count reflect a reserve or clear from the cycle after the edge.
- No handshake: every request completes in one edge; no backpressure.
- Read addresses may change at any time; outputs follow combinationally.

## Test plan
- Reset check: write 0xDEADBEEF to r5 and reserve r7, then assert reset between edges -> rd1(ra1=5)=0, busy1(ra1=7)=0 and busy_count=0 immediately, before any clock edge.
- Write/read and bypass: we=1, wa=3, wd=0x12345678, ra1=3 -> rd1=0x12345678 in the same cycle with BYPASS=1, and the old value with BYPASS=0; both configurations read 0x12345678 the next cycle.
- Zero register: write 0xFFFFFFFF to r0 and rsv_en on r0 -> rd1(ra1=0)=0, busy1=0, busy_count unchanged; with ZERO_REG=0, r0 stores and reads 0xFFFFFFFF.
- Scoreboard: reserve r4, r9 and r12 on successive cycles -> busy_count goes 1, 2, 3. Write r9 -> busy2(ra2=9)=0 and busy_count=2 the next cycle.
- Simultaneous reserve and write to r6 while busy: wd=0xA5A5A5A5 -> r6 reads 0xA5A5A5A5, busy stays 1 and busy_count is unchanged.
- Non-power-of-two depth, DEPTH=24: write to address 30 -> no array change; ra1=30 -> rd1=0 and busy1=0; reserving address 30 leaves busy_count unchanged.
